// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter merging two pixel requesters onto one VGA adapter write port.
// Optional full-screen clear sweep is compiled in when PLOT_CLEAR_EN is defined.
module vga_plot_arbiter #(
   parameter int unsigned XMAX         = 160,
   parameter int unsigned YMAX         = 120,
   parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_x,
   input  logic [13:0] req_y,
   input  logic [5:0]  req_colour,
   output logic [1:0]  req_ready,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        vga_resetn
);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e     state_q, state_d;
   logic       last_q, last_d;  // index of the requester granted most recently
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] colour_q, colour_d;
   logic       plot_q, plot_d;
   logic       resetn_q;

   logic [1:0] grant;
   logic       xfer;
   logic       sel;
   logic [7:0] sel_x;
   logic [6:0] sel_y;
   logic [2:0] sel_colour;
   logic       in_range;
   logic       clear_block;
   logic [7:0] clear_x;
   logic [6:0] clear_y;
   logic [2:0] clear_colour;

`ifdef PLOT_CLEAR_EN
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic       row_end;
   logic       last_pix;

   assign row_end  = (cx_q == 8'(XMAX - 1));
   assign last_pix = row_end && (cy_q == 7'(YMAX - 1));

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      unique case (state_q)
         StIdle: begin
            if (clear_start) begin
               state_d = StClear;
               cx_d    = 8'd0;
               cy_d    = 7'd0;
            end
         end
         StClear: begin
            if (last_pix) begin
               state_d = StIdle;
               cx_d    = 8'd0;
               cy_d    = 7'd0;
            end else if (row_end) begin
               cx_d = 8'd0;
               cy_d = cy_q + 7'd1;
            end else begin
               cx_d = cx_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cx_q <= 8'd0;
         cy_q <= 7'd0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

   assign clear_block  = clear_start;
   assign clear_busy   = (state_q == StClear);
   assign clear_x      = cx_q;
   assign clear_y      = cy_q;
   assign clear_colour = CLEAR_COLOUR;
`else
   logic unused_clear;

   always_comb begin
      state_d = StIdle;
   end

   assign unused_clear = ^{clear_start, CLEAR_COLOUR};
   assign clear_block  = 1'b0;
   assign clear_busy   = 1'b0;
   assign clear_x      = 8'd0;
   assign clear_y      = 7'd0;
   assign clear_colour = 3'b000;
`endif

   // Grants only in idle; a pending clear request locks both requesters out.
   always_comb begin
      grant = 2'b00;
      if ((state_q == StIdle) && !reset && !clear_block) begin
         unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready  = grant;
   assign xfer       = |grant;
   assign sel        = grant[1];
   assign sel_x      = sel ? req_x[15:8]      : req_x[7:0];
   assign sel_y      = sel ? req_y[13:7]      : req_y[6:0];
   assign sel_colour = sel ? req_colour[5:3]  : req_colour[2:0];
   assign in_range   = ({24'd0, sel_x} < XMAX) && ({25'd0, sel_y} < YMAX);

   always_comb begin
      last_d   = last_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      if (clear_busy) begin
         // Track the sweep so the last cleared pixel holds once the sweep ends.
         x_d      = clear_x;
         y_d      = clear_y;
         colour_d = clear_colour;
      end else if (xfer) begin
         last_d = sel;
         if (in_range) begin
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = sel_colour;
            plot_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         last_q   <= 1'b1;
         x_q      <= 8'd0;
         y_q      <= 7'd0;
         colour_q <= 3'b000;
         plot_q   <= 1'b0;
         resetn_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         resetn_q <= 1'b1;
      end
   end

   // The sweep drives the port directly so plot lines up with clear_busy.
   assign x          = clear_busy ? clear_x      : x_q;
   assign y          = clear_busy ? clear_y      : y_q;
   assign colour     = clear_busy ? clear_colour : colour_q;
   assign plot       = clear_busy | plot_q;
   assign vga_resetn = resetn_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomised and directed bench for vga_plot_arbiter against a transaction-level model.
// Clear-sweep scenarios are selected by PLOT_CLEAR_EN, matching the DUT build.
module tb_vga_plot_arbiter;

   localparam int XMAX = 160;
   localparam int YMAX = 120;
   localparam int NPIX = XMAX * YMAX;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [15:0] req_x;
   logic [13:0] req_y;
   logic [5:0]  req_colour;
   logic [1:0]  req_ready;
   logic        clear_start;
   logic        clear_busy;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        vga_resetn;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: who won last, and what the VGA port should show.
   int         rr_last;
   logic [7:0] exp_x;
   logic [6:0] exp_y;
   logic [2:0] exp_col;
   logic       exp_plot;

   vga_plot_arbiter dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .req_ready  (req_ready),
      .clear_start(clear_start),
      .clear_busy (clear_busy),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .vga_resetn (vga_resetn)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rr_last  = 1;
      exp_x    = 8'd0;
      exp_y    = 7'd0;
      exp_col  = 3'd0;
      exp_plot = 1'b0;
   endtask

   // One idle-state cycle: drive, check ready, advance one edge, check the pixel port.
   task automatic cycle(input logic [1:0] v,
                        input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] c0,
                        input logic [7:0] x1, input logic [6:0] y1, input logic [2:0] c1);
      int         w;
      logic [1:0] exp_rdy;
      logic [7:0] wx;
      logic [6:0] wy;
      logic [2:0] wc;
      req_valid   = v;
      req_x       = {x1, x0};
      req_y       = {y1, y0};
      req_colour  = {c1, c0};
      clear_start = 1'b0;
      #1;
      if (v == 2'b11) w = 1 - rr_last;
      else if (v == 2'b01) w = 0;
      else if (v == 2'b10) w = 1;
      else w = -1;
      exp_rdy = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      exp_plot = 1'b0;
      if (w >= 0) begin
         rr_last = w;
         wx = (w == 0) ? x0 : x1;
         wy = (w == 0) ? y0 : y1;
         wc = (w == 0) ? c0 : c1;
         if (int'(wx) < XMAX && int'(wy) < YMAX) begin
            exp_x    = wx;
            exp_y    = wy;
            exp_col  = wc;
            exp_plot = 1'b1;
         end
      end
      @(posedge CLOCK_50);
      #1;
      check_eq("plot", 32'(plot), 32'(exp_plot));
      check_eq("x", 32'(x), 32'(exp_x));
      check_eq("y", 32'(y), 32'(exp_y));
      check_eq("colour", 32'(colour), 32'(exp_col));
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = 2'b11;
      req_x       = 16'h2211;
      req_y       = 14'h0505;
      req_colour  = 6'o52;
      clear_start = 1'b0;
      model_reset();
      repeat (3) @(posedge CLOCK_50);
      #1;
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_x", 32'(x), 32'd0);
      check_eq("rst_y", 32'(y), 32'd0);
      check_eq("rst_colour", 32'(colour), 32'd0);
      check_eq("rst_plot", 32'(plot), 32'd0);
      check_eq("rst_busy", 32'(clear_busy), 32'd0);
      check_eq("rst_vga_resetn", 32'(vga_resetn), 32'd0);

      req_valid = 2'b00;
      reset     = 1'b0;
      #1;
      check_eq("vga_resetn_pre_edge", 32'(vga_resetn), 32'd0);
      @(posedge CLOCK_50);
      #1;
      check_eq("vga_resetn_post_edge", 32'(vga_resetn), 32'd1);

      // Contention straight after reset: grants must alternate starting at requester 0.
      cycle(2'b11, 8'd10, 7'd20, 3'd1, 8'd11, 7'd21, 3'd2);
      cycle(2'b11, 8'd12, 7'd22, 3'd3, 8'd13, 7'd23, 3'd4);
      cycle(2'b11, 8'd14, 7'd24, 3'd5, 8'd15, 7'd25, 3'd6);
      cycle(2'b11, 8'd16, 7'd26, 3'd7, 8'd17, 7'd27, 3'd0);

      cycle(2'b01, 8'd5, 7'd7, 3'd3, 8'd99, 7'd99, 3'd7);
      check_eq("single_x", 32'(x), 32'd5);
      check_eq("single_y", 32'(y), 32'd7);

      cycle(2'b01, 8'd160, 7'd0, 3'd6, 8'd0, 7'd0, 3'd0);
      check_eq("oor_x_hold", 32'(x), 32'd5);
      check_eq("oor_y_hold", 32'(y), 32'd7);
      cycle(2'b10, 8'd0, 7'd0, 3'd0, 8'd3, 7'd120, 3'd2);
      cycle(2'b00, 8'd1, 7'd1, 3'd1, 8'd2, 7'd2, 3'd2);

      for (int i = 0; i < 400; i++) begin
         cycle(2'($urandom_range(0, 3)),
               8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
      end

`ifdef PLOT_CLEAR_EN
      begin
         int k;
         int bad_pix;
         int bad_rdy;
         logic [7:0] first_x;
         logic [6:0] first_y;
         logic [7:0] last_x;
         logic [6:0] last_y;
         req_valid   = 2'b11;
         clear_start = 1'b1;
         #1;
         check_eq("clr_start_ready", 32'(req_ready), 32'd0);
         @(posedge CLOCK_50);
         #1;
         clear_start = 1'b0;
         k       = 0;
         bad_pix = 0;
         bad_rdy = 0;
         first_x = x;
         first_y = y;
         last_x  = 8'd0;
         last_y  = 7'd0;
         while (clear_busy === 1'b1 && k < NPIX + 100) begin
            if (plot !== 1'b1 || colour !== 3'b000 ||
                int'(x) != k % XMAX || int'(y) != k / XMAX) bad_pix++;
            if (req_ready !== 2'b00) bad_rdy++;
            last_x = x;
            last_y = y;
            k++;
            @(posedge CLOCK_50);
            #1;
         end
         check_eq("clr_busy_cycles", 32'(k), 32'(NPIX));
         check_eq("clr_bad_pixels", 32'(bad_pix), 32'd0);
         check_eq("clr_ready_during", 32'(bad_rdy), 32'd0);
         check_eq("clr_first_x", 32'(first_x), 32'd0);
         check_eq("clr_first_y", 32'(first_y), 32'd0);
         check_eq("clr_last_x", 32'(last_x), 32'(XMAX - 1));
         check_eq("clr_last_y", 32'(last_y), 32'(YMAX - 1));
         check_eq("clr_end_plot", 32'(plot), 32'd0);
         exp_x    = 8'(XMAX - 1);
         exp_y    = 7'(YMAX - 1);
         exp_col  = 3'b000;
         exp_plot = 1'b0;
         check_eq("clr_hold_x", 32'(x), 32'(exp_x));
         cycle(2'b11, 8'd40, 7'd41, 3'd5, 8'd42, 7'd43, 3'd6);
         cycle(2'b11, 8'd44, 7'd45, 3'd1, 8'd46, 7'd47, 3'd2);

         req_valid   = 2'b00;
         clear_start = 1'b1;
         @(posedge CLOCK_50);
         #1;
         clear_start = 1'b0;
         repeat (500) @(posedge CLOCK_50);
         #1;
         check_eq("mid_busy", 32'(clear_busy), 32'd1);
         check_eq("mid_x", 32'(x), 32'(500 % XMAX));
         check_eq("mid_y", 32'(y), 32'(500 / XMAX));
         reset = 1'b1;
         #1;
         check_eq("abort_plot", 32'(plot), 32'd0);
         check_eq("abort_busy", 32'(clear_busy), 32'd0);
         check_eq("abort_vga_resetn", 32'(vga_resetn), 32'd0);
         @(posedge CLOCK_50);
         #1;
         reset = 1'b0;
         model_reset();
         #1;
         check_eq("rel_vga_resetn_pre", 32'(vga_resetn), 32'd0);
         @(posedge CLOCK_50);
         #1;
         check_eq("rel_vga_resetn_post", 32'(vga_resetn), 32'd1);
         check_eq("rel_busy", 32'(clear_busy), 32'd0);
         check_eq("rel_plot", 32'(plot), 32'd0);
         cycle(2'b11, 8'd60, 7'd61, 3'd3, 8'd62, 7'd63, 3'd4);
         cycle(2'b11, 8'd64, 7'd65, 3'd5, 8'd66, 7'd67, 3'd6);
      end
`else
      begin
         int plots;
         req_valid   = 2'b00;
         clear_start = 1'b1;
         #1;
         check_eq("noclr_busy_start", 32'(clear_busy), 32'd0);
         @(posedge CLOCK_50);
         #1;
         clear_start = 1'b0;
         plots = 0;
         for (int i = 0; i < 8; i++) begin
            if (plot === 1'b1 || clear_busy !== 1'b0) plots++;
            @(posedge CLOCK_50);
            #1;
         end
         check_eq("noclr_quiet", 32'(plots), 32'd0);
         cycle(2'b11, 8'd70, 7'd71, 3'd1, 8'd72, 7'd73, 3'd2);
         cycle(2'b01, 8'd74, 7'd75, 3'd3, 8'd0, 7'd0, 3'd0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter XMAX, default 160: screen width in pixels; legal x is 0..XMAX-1.
REQ-002 Parameter YMAX, default 120: screen height in pixels; legal y is 0..YMAX-1.
REQ-003 Parameter CLEAR_COLOUR, default 3'b000: colour written by the clear sweep.
REQ-004 The block SHALL have these ports:
- CLOCK_50  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  bit i: requester i offers a pixel.
- req_x  input  16  requester i x at [8i+7:8i].
- req_y  input  14  requester i y at [7i+6:7i].
- req_colour  input  6  requester i colour at [3i+2:3i].
- req_ready  output  2  bit i: requester i's pixel accepted this cycle.
- clear_start  input  1  one-cycle request to start a full-screen clear.
- clear_busy  output  1  clear sweep in progress.
- x  output  8  VGA pixel x.
- y  output  7  VGA pixel y.
- colour  output  3  VGA pixel colour.
- plot  output  1  one-cycle pixel write strobe.
- vga_resetn  output  1  VGA adapter reset, active-low.

Function
REQ-005 The FSM SHALL have states IDLE and CLEAR.
REQ-006 A pixel transfers on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-007 req_ready SHALL be combinational and one-hot-or-zero: at most one bit set, only in IDLE, only when that requester is valid, never while reset or clear_start is high.
REQ-008 Arbitration SHALL be round-robin: with one requester valid, it wins; with both valid, the one not granted last wins; the last-grant pointer updates only on a transfer.
REQ-009 An accepted in-range pixel SHALL appear on x/y/colour with plot=1 on the next cycle (latency 1); plot SHALL be 0 on every cycle without an accepted pixel.
REQ-010 An accepted pixel with x>=XMAX or y>=YMAX SHALL be consumed (ready=1) but dropped: plot stays 0 and x/y/colour hold.
REQ-011 In IDLE, clear_start=1 SHALL enter CLEAR on the next edge; clear_start has priority over simultaneous req_valid.
REQ-012 CLEAR SHALL emit one pixel per cycle, plot=1, colour=CLEAR_COLOUR, x incrementing fastest 0..XMAX-1 and y 0..YMAX-1, for XMAX*YMAX cycles in total (19200 at defaults).
REQ-013 After pixel (XMAX-1,YMAX-1), the FSM SHALL return to IDLE; req_ready may assert in the following cycle.
REQ-014 clear_busy SHALL be 1 exactly on the cycles in state CLEAR; clear_start while in CLEAR SHALL be ignored.
REQ-015 vga_resetn SHALL be registered, 0 during reset and 1 from the first clock edge after reset deasserts.
REQ-016 x/y/colour SHALL hold their last value whenever plot=0.

Reset
REQ-017 While reset=1, outputs SHALL be x=0, y=0, colour=0, plot=0, req_ready=0, clear_busy=0 and vga_resetn=0; the FSM SHALL be in IDLE and the pointer SHALL favour requester 0 first.
REQ-018 Reset asserted mid-clear SHALL abort the sweep immediately; after release, the block is in IDLE with no resumption.

Configuration
REQ-019 With macro PLOT_CLEAR_EN defined, the CLEAR state and sweep counters SHALL be compiled in and behave per REQ-011..014.
REQ-020 Without PLOT_CLEAR_EN, clear_start SHALL be ignored, clear_busy SHALL be constant 0, the FSM SHALL remain in IDLE, and CLEAR_COLOUR SHALL be unused.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Single: req_valid=01, x=5, y=7, colour=3 -> req_ready=01 the same cycle; next cycle x=5, y=7, colour=3, plot=1.
- Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; four plot pulses with the matching coordinates.
- Out-of-range: req0 with x=160, y=0 -> req_ready[0]=1, plot stays 0, x/y unchanged.
- Clear (PLOT_CLEAR_EN): clear_start pulse together with req_valid=11 -> req_ready=00; clear_busy high for 19200 cycles; 19200 plots at colour 0, first (0,0), last (159,119); req_ready resumes afterwards.
- Reset mid-clear: assert reset at sweep pixel 500 -> plot=0, clear_busy=0 and vga_resetn=0 immediately; after release, IDLE and vga_resetn=1 after one edge.
- Build without PLOT_CLEAR_EN: clear_start pulse -> clear_busy=0, no plots, requesters served normally.
